reg_scoreboard: RTL

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 120 ++++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-write scoreboard for an in-order issue pipeline.
// Each architectural register 1..2^WIDTH-1 keeps a small count of writes that
// have been issued but have not yet reached Writeback. Decode is stalled while
// a source register has a write in flight, or while the destination counter
// is saturated.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active low
//   IssueValid     Decode requests issue this cycle
//   IssueRegWrite  issuing instruction writes IssueRd
//   IssueRd        destination register of the issuing instruction
//   Rs1ID/Rs2ID    source registers in Decode
//   RegWriteW      Writeback writes WriteRegWB this cycle
//   WriteRegWB     destination register in Writeback
//   Flush          discard every outstanding entry
//   ScoreStall     Decode must hold (combinational, from registered state)
//   IssueAccept    issue taken this cycle (combinational)
//   OutstandingCnt registered sum of all counters
//   Underflow      sticky: a writeback arrived for a register with count 0

// Per-register outstanding-write counter.
module reg_sb_cnt #(
  parameter int CNTW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inc,
  input  logic            i_dec,
  input  logic            i_flush,
  output logic [CNTW-1:0] o_cnt
);
  logic [CNTW-1:0] r_cnt;

  // Simultaneous inc and dec cancel out; the top never raises inc at max or
  // dec at zero, so the counter cannot wrap.
  always_ff @(posedge clk) begin
    if (!rst)                  r_cnt <= '0;
    else if (i_flush)          r_cnt <= '0;
    else if (i_inc && !i_dec)  r_cnt <= r_cnt + CNTW'(1);
    else if (i_dec && !i_inc)  r_cnt <= r_cnt - CNTW'(1);
  end

  assign o_cnt = r_cnt;
endmodule

module reg_scoreboard #(
  parameter int WIDTH = 5,
  parameter int CNTW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IssueValid,
  input  logic                  IssueRegWrite,
  input  logic [WIDTH-1:0]      IssueRd,
  input  logic [WIDTH-1:0]      Rs1ID,
  input  logic [WIDTH-1:0]      Rs2ID,
  input  logic                  RegWriteW,
  input  logic [WIDTH-1:0]      WriteRegWB,
  input  logic                  Flush,
  output logic                  ScoreStall,
  output logic                  IssueAccept,
  output logic [WIDTH+CNTW-1:0] OutstandingCnt,
  output logic                  Underflow
);
  localparam int NREG = 1 << WIDTH;

  logic [NREG-1:0][CNTW-1:0] w_cnt;
  logic w_rs1_pend, w_rs2_pend, w_rd_full;
  logic w_inc, w_dec, w_uf_set;
  logic [WIDTH+CNTW-1:0] r_out;
  logic r_uf;

  // x0 is hardwired: no counter, always reads zero.
  assign w_cnt[0] = '0;

  generate
    for (genvar g = 1; g < NREG; g++) begin : g_reg
      reg_sb_cnt #(.CNTW(CNTW)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_inc && (IssueRd == WIDTH'(g))),
        .i_dec   (w_dec && (WriteRegWB == WIDTH'(g))),
        .i_flush (Flush),
        .o_cnt   (w_cnt[g])
      );
    end
  endgenerate

  // Stall terms use pre-issue state only, so IssueRd may equal a source.
  assign w_rs1_pend = (Rs1ID != '0) && (w_cnt[Rs1ID] != '0);
  assign w_rs2_pend = (Rs2ID != '0) && (w_cnt[Rs2ID] != '0);
  assign w_rd_full  = IssueRegWrite && (IssueRd != '0) && (w_cnt[IssueRd] == '1);

  assign ScoreStall  = IssueValid && rst && (w_rs1_pend || w_rs2_pend || w_rd_full);
  assign IssueAccept = IssueValid && !ScoreStall && rst && !Flush;

  assign w_inc    = IssueAccept && IssueRegWrite && (IssueRd != '0);
  assign w_dec    = RegWriteW && (WriteRegWB != '0) && (w_cnt[WriteRegWB] != '0);
  // Writeback with nothing outstanding is dropped and flagged.
  assign w_uf_set = RegWriteW && (WriteRegWB != '0) && (w_cnt[WriteRegWB] == '0);

  // Total tracks the sum of counters incrementally; an inc and a dec in the
  // same cycle net to zero whether or not they hit the same register.
  always_ff @(posedge clk) begin
    if (!rst)                 r_out <= '0;
    else if (Flush)           r_out <= '0;
    else if (w_inc && !w_dec) r_out <= r_out + (WIDTH+CNTW)'(1);
    else if (w_dec && !w_inc) r_out <= r_out - (WIDTH+CNTW)'(1);
  end

  // Sticky until reset; Flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst)          r_uf <= 1'b0;
    else if (w_uf_set) r_uf <= 1'b1;
  end

  assign OutstandingCnt = r_out;
  assign Underflow      = r_uf;
endmodule
